// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Each pipeline stage resolves one SLICE_W-bit slice. Both slice sums are
// precomputed and the registered carry from the previous stage selects one.
module pipelined_csel_adder #(
    parameter int DATA_WIDTH = 24,
    parameter int N_STAGES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   result,
    output logic                  ovf
);
    localparam int SLICE_W = DATA_WIDTH / N_STAGES;

    // Per-stage payload. a/b keep the full operand so the slice for stage k
    // is always found at [k*SLICE_W +: SLICE_W]; sum fills in slice by slice.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;    // already inverted for subtraction
        logic [DATA_WIDTH-1:0] sum;
        logic                  carry;
        logic                  sub;
    } stage_t;

    stage_t              st_q [N_STAGES];
    stage_t              st_d [N_STAGES];
    logic [N_STAGES-1:0] vld_q;
    logic [N_STAGES-1:0] vin;
    logic [N_STAGES-1:0] load;
    logic                ovf_q;
    logic                ovf_d;

    // Flow control, input formatting and per-stage carry-select slice add.
    always_comb begin
        stage_t             src;
        logic [SLICE_W:0]   s0;
        logic [SLICE_W:0]   s1;
        logic [SLICE_W:0]   sel;

        // A stage loads when it is empty or its contents move on this cycle;
        // evaluated from the output end so back-pressure ripples to the input.
        load = '0;
        load[N_STAGES-1] = !vld_q[N_STAGES-1] || out_ready;
        for (int k = N_STAGES - 2; k >= 0; k--) begin
            load[k] = !vld_q[k] || load[k+1];
        end
        in_ready = load[0] && !reset;

        vin = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            src = st_q[(k == 0) ? 0 : k - 1];
            if (k == 0) begin
                src.a     = a;
                src.b     = sub ? ~b : b;
                src.sum   = '0;
                src.carry = sub;
                src.sub   = sub;
                vin[k]    = in_valid && in_ready;
            end else begin
                vin[k]    = vld_q[k-1];
            end
            s0  = {1'b0, src.a[k*SLICE_W +: SLICE_W]} + {1'b0, src.b[k*SLICE_W +: SLICE_W]};
            s1  = s0 + {{SLICE_W{1'b0}}, 1'b1};
            sel = src.carry ? s1 : s0;
            st_d[k] = src;
            st_d[k].sum[k*SLICE_W +: SLICE_W] = sel[SLICE_W-1:0];
            st_d[k].carry = sel[SLICE_W];
        end

        // Signed overflow: operands agree in sign but the sum does not.
        ovf_d = (st_d[N_STAGES-1].a[DATA_WIDTH-1] == st_d[N_STAGES-1].b[DATA_WIDTH-1]) &&
                (st_d[N_STAGES-1].sum[DATA_WIDTH-1] != st_d[N_STAGES-1].a[DATA_WIDTH-1]);
    end

    // Valid bits: cleared by reset, otherwise follow the load enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (load[k]) vld_q[k] <= vin[k];
            end
        end
    end

    // Data registers carry no reset; outputs are masked by the valid bit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_STAGES; k++) begin
            if (load[k]) st_q[k] <= st_d[k];
        end
        if (load[N_STAGES-1]) ovf_q <= ovf_d;
    end

    assign out_valid = vld_q[N_STAGES-1];
    assign result    = out_valid ? {st_q[N_STAGES-1].carry, st_q[N_STAGES-1].sum} : '0;
    assign ovf       = out_valid && ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder: queue-based arithmetic model,
// literal corner cases, back-pressure, and reset with beats in flight.
module tb_pipelined_csel_adder;
    localparam int DW = 24;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW:0]   result;
    logic          ovf;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_out  = 0;
    int cyc    = 0;

    typedef struct {
        logic [DW:0] res;
        logic        ovf;
    } exp_t;
    exp_t q[$];

    pipelined_csel_adder #(.DATA_WIDTH(DW), .N_STAGES(NS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer add/subtract on the whole word.
    function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s);
        exp_t          e;
        logic [DW-1:0] yp;
        yp    = s ? ~y : y;
        e.res = {1'b0, x} + {1'b0, yp} + {{DW{1'b0}}, s};
        e.ovf = (x[DW-1] == yp[DW-1]) && (e.res[DW-1] != x[DW-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: handshakes sampled mid-cycle predict the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
        end else begin
            if (!out_valid) begin
                check("idle_outputs_zero", {result, ovf}, 0);
            end else if (out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {1'b1, result}, 0);
                end else begin
                    e = q.pop_front();
                    check("result", result, e.res);
                    check("ovf", ovf, e.ovf);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub));
                n_acc++;
            end
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic push_beat(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s);
        bit acc;
        int t;
        a = x; b = y; sub = s; in_valid = 1'b1;
        acc = 0; t = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end
        check("push_accepted", {63'd0, acc}, 1);
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe; checks latency and literal result.
    task automatic send_one(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s,
                            input logic [DW:0] exp_res, input logic exp_ovf, input string name);
        int lat;
        check({name, "_in_ready"}, in_ready, 1);
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, NS);
        check({name, "_result"}, result, exp_res);
        check({name, "_ovf"}, ovf, exp_ovf);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] sa [6];
        logic [DW-1:0] sb [6];
        logic [DW:0]   held;
        int idx, c0, o0, t;
        bit acc;

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", in_ready, 1);

        // Literal corner cases
        send_one(24'hFFFFFF, 24'd1, 1'b0, 25'h1000000, 1'b0, "add_wrap");
        send_one(24'd5, 24'd7, 1'b1, 25'h0FFFFFE, 1'b0, "sub_borrow");
        send_one(24'd7, 24'd5, 1'b1, 25'h1000002, 1'b0, "sub_noborrow");
        send_one(24'h7FFFFF, 24'd1, 1'b0, 25'h0800000, 1'b1, "add_ovf");
        send_one(24'h800000, 24'd1, 1'b1, 25'h17FFFFF, 1'b1, "sub_ovf");
        ra = DW'($urandom);
        send_one(ra, 24'd0, 1'b1, {1'b1, ra}, 1'b0, "sub_zero");

        // 200 random back-to-back beats, no back-pressure
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 200; i++) push_beat(DW'($urandom), DW'($urandom), 1'($urandom));
        check("b2b_one_per_cycle", cyc - c0, 200);
        drain();

        // Stall: out_ready=0 with 6 beats offered
        for (int i = 0; i < 6; i++) begin
            sa[i] = DW'($urandom); sb[i] = DW'($urandom);
        end
        out_ready = 1'b0;
        o0 = n_out;
        idx = 0;
        held = '0;
        for (int c = 0; c < 10; c++) begin
            a = sa[idx < 6 ? idx : 5]; b = sb[idx < 6 ? idx : 5]; sub = idx[0];
            in_valid = (idx < 6);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (c == 6) held = result;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("stall_accepted", idx, 4);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_result_held", result, held);
        out_ready = 1'b1;
        t = 0;
        while (idx < 6 && t < 50) begin
            a = sa[idx]; b = sb[idx]; sub = idx[0]; in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            t++;
        end
        in_valid = 1'b0;
        drain();
        check("stall_results_out", n_out - o0, 6);

        // Random traffic with random back-pressure
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = DW'($urandom);
            b         = DW'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        check("acc_eq_out", n_acc, n_out);

        // Reset with three beats in flight
        push_beat(24'h111111, 24'h222222, 1'b0);
        push_beat(24'h333333, 24'h000001, 1'b1);
        push_beat(24'hABCDEF, 24'h123456, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        #1;
        check("rst_in_ready_high", in_ready, 1);
        send_one(24'd7, 24'd5, 1'b1, 25'h1000002, 1'b0, "after_reset");
        repeat (8) @(posedge clk);
        #1;
        check("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
